// File: rtl/bus_arbiter.sv
// Purpose : arbitrates an instruction-fetch port and a load/store port onto one shared bus, one transfer at a time.
// Latency : at least 4 edges from grant to ack (IDLE->ADDR->DATA->RESP->ack); each HREADY-low DATA cycle adds one edge.
// Backpr. : requesters hold their request until ack; DATA stalls while HREADY=0; flush drops an in-flight fetch result.
// Ports   : CLK/RST (async active-high); if_req/if_addr -> if_ack/if_rdata; mem_req/mem_write/mem_addr/mem_wdata
//           -> mem_ack/mem_rdata; flush; bus side HADDR/HWDATA/HWRITE/HTRANS out, HRDATA/HREADY in.
module bus_arbiter #(
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [63:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic        mem_ack,
    output logic [63:0] mem_rdata,
    input  logic        flush,
    output logic [63:0] HADDR,
    output logic [63:0] HWDATA,
    output logic        HWRITE,
    output logic        HTRANS,
    input  logic [63:0] HRDATA,
    input  logic        HREADY
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    // Streak counter is at least 3 bits wide, wider only if the limit needs it.
    localparam int SW = (MEM_STREAK_MAX < 8) ? 3 : $clog2(MEM_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MEM_STREAK_MAX);

    state_t        state_q, state_d;
    logic          owner_mem_q, owner_mem_d;
    logic          drop_q, drop_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [63:0]   haddr_q, haddr_d;
    logic [63:0]   hwdata_q, hwdata_d;
    logic          hwrite_q, hwrite_d;
    logic          htrans_q, htrans_d;
    logic          if_ack_q, if_ack_d;
    logic          mem_ack_q, mem_ack_d;
    logic [63:0]   if_rdata_q, if_rdata_d;
    logic [63:0]   mem_rdata_q, mem_rdata_d;
    logic          grant_mem, grant_if;

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        drop_d      = drop_q;
        streak_d    = streak_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        hwrite_d    = hwrite_q;
        htrans_d    = 1'b0;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        // MEM wins by default; IF only overrides once MEM has used up its streak.
        grant_mem   = 1'b0;
        grant_if    = 1'b0;

        case (state_q)
            IDLE: begin
                grant_mem = mem_req && !(if_req && !flush && (streak_q == STREAK_MAX));
                grant_if  = if_req && !flush && !grant_mem;
                if (!mem_req) begin
                    streak_d = '0;
                end
                if (grant_mem) begin
                    owner_mem_d = 1'b1;
                    haddr_d     = mem_addr;
                    hwrite_d    = mem_write;
                    if (mem_write) begin
                        hwdata_d = mem_wdata;
                    end
                    htrans_d = 1'b1;
                    state_d  = ADDR;
                    if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant_if) begin
                    owner_mem_d = 1'b0;
                    haddr_d     = if_addr;
                    hwrite_d    = 1'b0;
                    htrans_d    = 1'b1;
                    streak_d    = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (!owner_mem_q && flush) begin
                    drop_d = 1'b1;
                end
                state_d = DATA;
            end
            DATA: begin
                if (!owner_mem_q && flush) begin
                    drop_d = 1'b1;
                end
                if (HREADY) begin
                    state_d = RESP;
                    if (owner_mem_q) begin
                        if (!hwrite_q) begin
                            mem_rdata_d = HRDATA;
                        end
                    end else if (!drop_q && !flush) begin
                        // A flush on the completing edge itself also discards the fetch.
                        if_rdata_d = HRDATA;
                    end
                end
            end
            RESP: begin
                // The ack flop is set from RESP, so the pulse lands on the edge leaving RESP.
                if (owner_mem_q) begin
                    mem_ack_d = 1'b1;
                end else if (!drop_q) begin
                    if_ack_d = 1'b1;
                end
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            owner_mem_q <= 1'b0;
            drop_q      <= 1'b0;
            streak_q    <= '0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            drop_q      <= drop_d;
            streak_q    <= streak_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HTRANS    = htrans_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose : directed self-checking bench for bus_arbiter.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpr. : every wait on an ack is bounded; a timeout counts as a failure.
module tb_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_req, mem_req, mem_write, flush, HREADY;
    logic [63:0] if_addr, mem_addr, mem_wdata, HRDATA;
    logic        if_ack, mem_ack, HWRITE, HTRANS;
    logic [63:0] if_rdata, mem_rdata, HADDR, HWDATA;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(.MEM_STREAK_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .flush(flush),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HRDATA(HRDATA), .HREADY(HREADY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns the number of edges until the selected ack is seen, or -1 on timeout.
    task automatic edges_to_ack(input bit is_mem, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((is_mem ? mem_ack : if_ack) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        if_req = 0; mem_req = 0; mem_write = 0; flush = 0; HREADY = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; HRDATA = '0;
        #2;
        checks++;
        if ({HTRANS, HWRITE, if_ack, mem_ack} !== 4'b0 || HADDR !== 64'd0 || HWDATA !== 64'd0 ||
            if_rdata !== 64'd0 || mem_rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: htrans=%b hwrite=%b acks=%b%b haddr=%h hwdata=%h rd=%h/%h required all zero",
                     HTRANS, HWRITE, if_ack, mem_ack, HADDR, HWDATA, if_rdata, mem_rdata);
        end
        tick(); tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_if_read();
        int n;
        if_req = 1; if_addr = 64'h1000; HREADY = 1; HRDATA = 64'hDEAD;
        tick();
        checks++;
        if (HTRANS !== 1'b1 || HADDR !== 64'h1000 || HWRITE !== 1'b0) begin
            failures++;
            $display("FAIL if_read_addr: htrans=%b haddr=%h hwrite=%b required 1/1000/0", HTRANS, HADDR, HWRITE);
        end
        tick();
        checks++;
        if (HTRANS !== 1'b0) begin
            failures++;
            $display("FAIL if_read_htrans_one_cycle: htrans=%b required 0", HTRANS);
        end
        edges_to_ack(1'b0, 10, n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL if_read_latency: ack after %0d edges required 4", (n < 0) ? n : n + 2);
        end
        checks++;
        if (if_rdata !== 64'hDEAD) begin
            failures++;
            $display("FAIL if_read_rdata: got %h required dead", if_rdata);
        end
        if_req = 0;
        tick();
        checks++;
        if (if_ack !== 1'b0) begin
            failures++;
            $display("FAIL if_ack_pulse: ack=%b required 0 one cycle later", if_ack);
        end
        tick();
    endtask

    task automatic test_mem_store();
        int n;
        mem_req = 1; mem_write = 1; mem_addr = 64'h2008; mem_wdata = 64'h55; HREADY = 0; HRDATA = 64'hBEEF;
        tick();
        checks++;
        if (HTRANS !== 1'b1 || HWRITE !== 1'b1 || HWDATA !== 64'h55 || HADDR !== 64'h2008) begin
            failures++;
            $display("FAIL store_addr: htrans=%b hwrite=%b hwdata=%h haddr=%h required 1/1/55/2008",
                     HTRANS, HWRITE, HWDATA, HADDR);
        end
        tick(); tick(); tick(); tick();   // ADDR->DATA, then three HREADY-low DATA edges
        HREADY = 1;
        edges_to_ack(1'b1, 10, n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL store_latency: ack after %0d edges required 7", (n < 0) ? n : n + 5);
        end
        checks++;
        if (mem_rdata !== 64'd0) begin
            failures++;
            $display("FAIL store_no_rdata: mem_rdata=%h required 0", mem_rdata);
        end
        mem_req = 0; mem_write = 0;
        tick(); tick();
    endtask

    task automatic test_mem_load();
        int n;
        mem_req = 1; mem_write = 0; mem_addr = 64'hFFFF_0000_0000_3000;
        HREADY = 1; HRDATA = 64'h1234_5678_9ABC_DEF0;
        tick();
        checks++;
        if (HTRANS !== 1'b1 || HWRITE !== 1'b0 || HWDATA !== 64'h55 || HADDR !== 64'hFFFF_0000_0000_3000) begin
            failures++;
            $display("FAIL load_addr: htrans=%b hwrite=%b hwdata=%h haddr=%h required 1/0/55/ffff000000003000",
                     HTRANS, HWRITE, HWDATA, HADDR);
        end
        edges_to_ack(1'b1, 10, n);
        checks++;
        if (n !== 3 || mem_rdata !== 64'h1234_5678_9ABC_DEF0) begin
            failures++;
            $display("FAIL load_data: edges=%0d rdata=%h required 4/123456789abcdef0", (n < 0) ? n : n + 1, mem_rdata);
        end
        checks++;
        if (if_rdata !== 64'hDEAD) begin
            failures++;
            $display("FAIL load_if_rdata_hold: if_rdata=%h required dead", if_rdata);
        end
        mem_req = 0;
        tick(); tick();
    endtask

    task automatic test_contention();
        string expected, got;
        int grants;
        expected = "MMMMIMMMMI";
        got = "";
        grants = 0;
        if_req = 1; if_addr = 64'h1000; mem_req = 1; mem_write = 0; mem_addr = 64'h2000;
        HREADY = 1; HRDATA = 64'hC0DE;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            tick();
            if (HTRANS === 1'b1) begin
                got = {got, (HADDR === 64'h2000) ? "M" : "I"};
                grants++;
            end
        end
        if_req = 0; mem_req = 0;
        for (int g = 0; g < 10; g++) begin
            checks++;
            if (g >= got.len() || got[g] != expected[g]) begin
                failures++;
                $display("FAIL contention_grant%0d: order %s required %s", g, got, expected);
            end
        end
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if (if_rdata !== 64'hC0DE) begin
            failures++;
            $display("FAIL contention_if_rdata: got %h required c0de", if_rdata);
        end
    endtask

    task automatic test_flush();
        int n;
        bit saw_ack;
        if_req = 1; if_addr = 64'h1100; HREADY = 0; HRDATA = 64'hF00D;
        tick(); tick();                    // grant, then into DATA
        flush = 1; if_req = 0;
        tick();                            // DATA edge with flush set
        flush = 0; HREADY = 1;
        saw_ack = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (if_ack === 1'b1) saw_ack = 1;
        end
        checks++;
        if (saw_ack !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_ack: if_ack seen=%b required 0", saw_ack);
        end
        checks++;
        if (if_rdata !== 64'hC0DE) begin
            failures++;
            $display("FAIL flush_rdata_hold: if_rdata=%h required c0de", if_rdata);
        end
        if_req = 1; flush = 1; HRDATA = 64'h7777;
        tick();
        checks++;
        if (HTRANS !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_block: htrans=%b required 0", HTRANS);
        end
        flush = 0;
        edges_to_ack(1'b0, 10, n);
        checks++;
        if (n !== 4 || if_rdata !== 64'h7777) begin
            failures++;
            $display("FAIL flush_recover: edges=%0d rdata=%h required 4/7777", n, if_rdata);
        end
        if_req = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int n;
        if_req = 1; if_addr = 64'h4000; HREADY = 0; HRDATA = 64'h9999;
        tick(); tick(); tick();            // grant, DATA, one stalled DATA edge
        #2 RST = 1;
        #1;
        checks++;
        if ({HTRANS, HWRITE, if_ack, mem_ack} !== 4'b0 || HADDR !== 64'd0 || HWDATA !== 64'd0 ||
            if_rdata !== 64'd0 || mem_rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: htrans=%b hwrite=%b acks=%b%b haddr=%h hwdata=%h rd=%h/%h required all zero",
                     HTRANS, HWRITE, if_ack, mem_ack, HADDR, HWDATA, if_rdata, mem_rdata);
        end
        HREADY = 1; HRDATA = 64'hABCD;
        #1 RST = 0;
        edges_to_ack(1'b0, 10, n);
        checks++;
        if (n !== 4 || if_rdata !== 64'hABCD || HADDR !== 64'h4000) begin
            failures++;
            $display("FAIL reset_mid_recover: edges=%0d rdata=%h haddr=%h required 4/abcd/4000", n, if_rdata, HADDR);
        end
        if_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_store();
        test_mem_load();
        test_contention();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_STREAK_MAX, default 4: the maximum number of consecutive MEM grants while IF is waiting.
REQ-002 CLK  in  1  system clock; all state SHALL change on the rising edge only.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch read request; held until if_ack.
REQ-005 if_addr  in  64  fetch address; stable while if_req is high.
REQ-006 if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-007 if_rdata  out  64  fetch read data; holds its value until the next IF completion.
REQ-008 mem_req  in  1  load/store request; held until mem_ack.
REQ-009 mem_write  in  1  1 = store, 0 = load.
REQ-010 mem_addr  in  64  and  mem_wdata  in  64: load/store address and store data.
REQ-011 mem_ack  out  1  one-cycle pulse: load/store complete.
REQ-012 mem_rdata  out  64  load data; holds its value until the next MEM load completion.
REQ-013 flush  in  1  branch-taken flush; cancels fetch traffic.
REQ-014 HADDR  out  64,  HWDATA  out  64,  HWRITE  out  1,  HTRANS  out  1: shared bus request signals.
REQ-015 HRDATA  in  64,  HREADY  in  1: bus read data and transfer-done signal.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA, RESP; at any time at most one transfer SHALL be outstanding.
REQ-017 IDLE SHALL arbitrate as follows.
- Only mem_req: MEM wins.
- Only if_req with flush=0: IF wins.
- Both, flush=0: MEM wins unless streak==MEM_STREAK_MAX, in which case IF wins.
- No request: stay in IDLE.
REQ-018 On a win, the block SHALL latch the owner, HADDR, and HWRITE (1 only for a MEM store), load HWDATA only for stores (otherwise hold it), set HTRANS=1, and go to ADDR.
REQ-019 ADDR SHALL last exactly one cycle: HTRANS returns to 0 at the next edge and the FSM goes to DATA.
REQ-020 DATA SHALL wait for HREADY=1. At that edge the block SHALL capture HRDATA into the owner's rdata (no capture for stores) and go to RESP.
REQ-021 RESP SHALL pulse the owner's ack for exactly one cycle, then return unconditionally to IDLE; no arbitration occurs in RESP.
REQ-022 Minimum transfer latency SHALL be 4 edges from request sampled to ack, i.e. HREADY=1 in the first DATA cycle.
REQ-023 streak is a 3-bit or wider saturating counter.
- Increment on each MEM grant; saturate at MEM_STREAK_MAX.
- Clear to 0 on each IF grant.
- Clear to 0 when IDLE sees mem_req=0.
REQ-024 Flush handling:
- flush=1 in IDLE SHALL block an IF grant that cycle.
- flush=1 while the owner is IF (ADDR/DATA) SHALL set a drop flag; the bus transfer completes normally, but if_ack and the if_rdata update are suppressed.
- The drop flag SHALL clear on entry to IDLE.
REQ-025 flush SHALL NOT affect MEM transfers.
REQ-026 A request that drops before grant SHALL be ignored. Request inputs SHALL NOT be re-sampled after grant; the latched values are used.
REQ-027 Addresses and data SHALL pass through at full 64-bit width, with no alignment or wrap checking.

Reset
REQ-028 On RST=1, immediately and independent of CLK:
- state = IDLE; HTRANS = HWRITE = 0.
- HADDR = HWDATA = 0.
- if_ack = mem_ack = 0; if_rdata = mem_rdata = 0.
- streak = 0; drop = 0.
REQ-029 RST asserted mid-transfer SHALL abandon the transfer with no ack; after release, the first edge arbitrates from IDLE.

Verification
REQ-030 IF read alone: if_req=1, if_addr=0x1000, HREADY=1 always, HRDATA=0xDEAD -> HTRANS=1 for one cycle with HADDR=0x1000, HWRITE=0; if_ack pulses 4 edges after the request with if_rdata=0xDEAD.
REQ-031 MEM store with wait states: mem_write=1, mem_addr=0x2008, mem_wdata=0x55, HREADY low for 3 DATA cycles -> HWRITE=1, HWDATA=0x55; mem_ack arrives 7 edges after the request; mem_rdata unchanged.
REQ-032 Contention: if_req and mem_req held high continuously with MEM_STREAK_MAX=4 -> grant order M,M,M,M,I,M,M,M,M,I.
REQ-033 Flush: flush=1 during the DATA phase of an IF transfer -> the bus completes, no if_ack, if_rdata unchanged; flush=1 in IDLE with only if_req -> no HTRANS that cycle.
REQ-034 Reset mid-DATA: RST pulsed while waiting for HREADY -> all outputs 0 immediately, no ack, and a clean IF transfer completes after release.
